// File: rtl/sparse_spill_buffer_if.sv
// sparse_spill_buffer_if: write-allocate / read-release bundle between a PE row and the shared spill buffer.
interface sparse_spill_buffer_if #(
    parameter int N_CH  = 8,
    parameter int DEPTH = 32,
    parameter int DW    = 16,
    parameter int IW    = 5,
    parameter int AW    = $clog2(DEPTH)
);
    logic [N_CH-1:0]    wr_req, wr_gnt, rd_req, rd_free, rd_valid, rd_err;
    logic [N_CH*DW-1:0] wr_data, rd_data;
    logic [N_CH*IW-1:0] wr_idx, rd_idx;
    logic [N_CH*AW-1:0] wr_slot, rd_slot;
    logic               full, empty;

    modport master (
        output wr_req, wr_data, wr_idx, rd_req, rd_slot, rd_free,
        input  wr_gnt, wr_slot, rd_valid, rd_data, rd_idx, rd_err, full, empty
    );
    modport slave (
        input  wr_req, wr_data, wr_idx, rd_req, rd_slot, rd_free,
        output wr_gnt, wr_slot, rd_valid, rd_data, rd_idx, rd_err, full, empty
    );
endinterface

// File: rtl/sparse_spill_buffer.sv
// sparse_spill_buffer: shared {data, index} spill store with per-channel lowest-free-slot allocation.
// SPILL_OCCUPANCY_EN adds registered occ_cnt and high_water outputs.
module sparse_spill_buffer #(
    parameter int N_CH  = 8,
    parameter int DEPTH = 32,
    parameter int DW    = 16,
    parameter int IW    = 5,
    parameter int AW    = $clog2(DEPTH)
`ifdef SPILL_OCCUPANCY_EN
    , localparam int CW = $clog2(DEPTH + 1)
`endif
) (
    input logic clk,
    input logic rst_n,
    sparse_spill_buffer_if.slave bus
`ifdef SPILL_OCCUPANCY_EN
    , output logic [CW-1:0] occ_cnt
    , output logic [CW-1:0] high_water
`endif
);
    localparam int WW = DW + IW;

    logic [WW-1:0]      mem [DEPTH];
    logic [DEPTH-1:0]   occ_q, occ_d, avail, set_m, clr_m;
    logic [N_CH-1:0]    gnt;
    logic [N_CH*AW-1:0] slot;
    logic               found, hit;
    logic [AW-1:0]      rs;
    logic [N_CH-1:0]    rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
    logic [N_CH*DW-1:0] rd_data_q, rd_data_d;
    logic [N_CH*IW-1:0] rd_idx_q, rd_idx_d;

    // avail loses each slot as it is handed out, so lower channels win the lowest slots
    always_comb begin
        avail = ~occ_q;
        gnt   = '0;
        slot  = '0;
        found = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            found = 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                if (bus.wr_req[c] && !found && avail[s]) begin
                    found               = 1'b1;
                    gnt[c]              = 1'b1;
                    slot[c*AW +: AW]    = AW'(s);
                    avail[s]            = 1'b0;
                end
            end
        end
        set_m = ~occ_q & ~avail;
    end

    always_comb begin
        rd_valid_d = '0;
        rd_err_d   = '0;
        rd_data_d  = rd_data_q;
        rd_idx_d   = rd_idx_q;
        clr_m      = '0;
        rs         = '0;
        hit        = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            rs  = bus.rd_slot[c*AW +: AW];
            hit = occ_q[rs];
            if (bus.rd_req[c]) begin
                rd_valid_d[c] = hit;
                rd_err_d[c]   = !hit;
                if (hit) {rd_data_d[c*DW +: DW], rd_idx_d[c*IW +: IW]} = mem[rs];
                if (hit && bus.rd_free[c]) clr_m[rs] = 1'b1;
            end
        end
        occ_d = (occ_q | set_m) & ~clr_m;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= '0;
            rd_valid_q <= '0;
            rd_err_q   <= '0;
            rd_data_q  <= '0;
            rd_idx_q   <= '0;
        end else begin
            occ_q      <= occ_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    // array is left unreset; occupancy alone decides what is readable
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++)
            if (gnt[c]) mem[slot[c*AW +: AW]] <= {bus.wr_data[c*DW +: DW], bus.wr_idx[c*IW +: IW]};
    end

    assign bus.wr_gnt   = gnt;
    assign bus.wr_slot  = slot;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_idx   = rd_idx_q;
    assign bus.full     = &occ_q;
    assign bus.empty    = ~|occ_q;

`ifdef SPILL_OCCUPANCY_EN
    logic [CW-1:0] cnt, occ_cnt_q, high_water_q;

    assign cnt = CW'($countones(occ_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_cnt_q    <= '0;
            high_water_q <= '0;
        end else begin
            occ_cnt_q    <= cnt;
            high_water_q <= cnt > high_water_q ? cnt : high_water_q;
        end
    end

    assign occ_cnt    = occ_cnt_q;
    assign high_water = high_water_q;
`endif
endmodule

// File: tb/tb_sparse_spill_buffer.sv
// tb_sparse_spill_buffer: directed vector table plus hand sequences for reset, fill and drain.
module tb_sparse_spill_buffer;
    typedef struct packed {
        logic [7:0]      wr_req;
        logic [7:0]      rd_req;
        logic [7:0]      rd_free;
        logic [7:0][4:0] rd_slot;
        logic [7:0]      gnt;
        logic [7:0][4:0] slot;
        logic [7:0]      valid;
        logic [7:0]      err;
        logic            full;
        logic            empty;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t tbl [11];
    vec_t t;
    logic [20:0]  mem_m [32];
    logic [20:0]  exp_w [8];
    logic [127:0] ed, ei;

    sparse_spill_buffer_if #(.N_CH(8), .DEPTH(32), .DW(16), .IW(5), .AW(5)) bus ();

`ifdef SPILL_OCCUPANCY_EN
    logic [5:0] occ_cnt, high_water;
    sparse_spill_buffer #(.N_CH(8), .DEPTH(32), .DW(16), .IW(5), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .occ_cnt(occ_cnt), .high_water(high_water));
`else
    sparse_spill_buffer #(.N_CH(8), .DEPTH(32), .DW(16), .IW(5), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    function automatic logic [7:0][4:0] all_s(input logic [4:0] s);
        for (int c = 0; c < 8; c++) all_s[c] = s;
    endfunction

    function automatic logic [7:0][4:0] seq_s(input int b);
        for (int c = 0; c < 8; c++) seq_s[c] = 5'(b + c);
    endfunction

    function automatic vec_t mk(input logic [7:0] wr, rr, rf, input logic [7:0][4:0] rs,
                                input logic [7:0] g, input logic [7:0][4:0] sl,
                                input logic [7:0] va, er, input logic f, e);
        mk = '{wr, rr, rf, rs, g, sl, va, er, f, e};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string n);
        for (int c = 0; c < 8; c++) begin
            ed[c*16 +: 16] = exp_w[c][20:5];
            ei[c*5 +: 5]   = exp_w[c][4:0];
        end
        chk({n, " rd_data"}, 128'(bus.rd_data), ed);
        chk({n, " rd_idx"}, 128'(bus.rd_idx), ei);
    endtask

    initial begin
        tbl[0]  = mk(8'hFF, 8'h00, 8'h00, all_s(0),  8'hFF, seq_s(0),  8'h00, 8'h00, 1'b0, 1'b0);
        tbl[1]  = mk(8'hFF, 8'h01, 8'h00, all_s(5),  8'hFF, seq_s(8),  8'h01, 8'h00, 1'b0, 1'b0);
        tbl[2]  = mk(8'hFF, 8'h04, 8'h00, all_s(12), 8'hFF, seq_s(16), 8'h04, 8'h00, 1'b0, 1'b0);
        tbl[3]  = mk(8'hFF, 8'h80, 8'h00, all_s(24), 8'hFF, seq_s(24), 8'h00, 8'h80, 1'b1, 1'b0);
        tbl[4]  = mk(8'h08, 8'h80, 8'h80, all_s(17), 8'h00, '0,        8'h80, 8'h00, 1'b0, 1'b0);
        tbl[5]  = mk(8'h08, 8'h00, 8'h00, all_s(0),  8'h08, '0,        8'h00, 8'h00, 1'b1, 1'b0);
        tbl[5].slot[3] = 5'd17;
        tbl[6]  = mk(8'h00, 8'h11, 8'h11, all_s(9),  8'h00, '0,        8'h11, 8'h00, 1'b0, 1'b0);
        tbl[6].rd_slot[4] = 5'd20;
        tbl[7]  = mk(8'h52, 8'h00, 8'h00, all_s(0),  8'h12, '0,        8'h00, 8'h00, 1'b1, 1'b0);
        tbl[7].slot[1] = 5'd9;
        tbl[7].slot[4] = 5'd20;
        tbl[8]  = mk(8'h40, 8'h81, 8'h81, all_s(2),  8'h00, '0,        8'h81, 8'h00, 1'b0, 1'b0);
        tbl[9]  = mk(8'h40, 8'h01, 8'h00, all_s(2),  8'h40, '0,        8'h00, 8'h01, 1'b1, 1'b0);
        tbl[9].slot[6] = 5'd2;
        tbl[10] = mk(8'h00, 8'h08, 8'h00, all_s(2),  8'h00, '0,        8'h08, 8'h00, 1'b1, 1'b0);

        for (int c = 0; c < 8; c++) exp_w[c] = '0;
        for (int s = 0; s < 32; s++) mem_m[s] = '0;
        bus.wr_req = '0; bus.rd_req = '0; bus.rd_free = '0; bus.rd_slot = '0;
        bus.wr_data = '0; bus.wr_idx = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("idle empty", 128'(bus.empty), 128'(1));
        chk("idle full", 128'(bus.full), 128'(0));
        chk("idle rd_valid", 128'(bus.rd_valid), 128'(0));
        chk("idle rd_err", 128'(bus.rd_err), 128'(0));
        chk("idle gnt", 128'(bus.wr_gnt), 128'(0));

        for (int i = 0; i < 11; i++) begin
            t = tbl[i];
            bus.wr_req = t.wr_req; bus.rd_req = t.rd_req; bus.rd_free = t.rd_free; bus.rd_slot = t.rd_slot;
            for (int c = 0; c < 8; c++) begin
                bus.wr_data[c*16 +: 16] = {4'h1, 4'(i), 8'(c)};
                bus.wr_idx[c*5 +: 5]    = 5'(c);
            end
            #1;
            chk($sformatf("v%0d gnt", i), 128'(bus.wr_gnt), 128'(t.gnt));
            for (int c = 0; c < 8; c++)
                if (t.gnt[c]) chk($sformatf("v%0d slot ch%0d", i, c), 128'(bus.wr_slot[c*5 +: 5]), 128'(t.slot[c]));
            for (int c = 0; c < 8; c++)
                if (t.valid[c]) exp_w[c] = mem_m[t.rd_slot[c]];
            for (int c = 0; c < 8; c++)
                if (t.gnt[c]) mem_m[t.slot[c]] = {4'h1, 4'(i), 8'(c), 5'(c)};
            step();
            chk($sformatf("v%0d rd_valid", i), 128'(bus.rd_valid), 128'(t.valid));
            chk($sformatf("v%0d rd_err", i), 128'(bus.rd_err), 128'(t.err));
            check_outs($sformatf("v%0d", i));
            chk($sformatf("v%0d full", i), 128'(bus.full), 128'(t.full));
            chk($sformatf("v%0d empty", i), 128'(bus.empty), 128'(t.empty));
        end

        // asynchronous reset in the middle of a full-buffer cycle
        bus.wr_req = 8'hFF; bus.rd_req = 8'h00; bus.rd_free = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) exp_w[c] = '0;
        chk("arst full", 128'(bus.full), 128'(0));
        chk("arst empty", 128'(bus.empty), 128'(1));
        chk("arst rd_valid", 128'(bus.rd_valid), 128'(0));
        chk("arst rd_err", 128'(bus.rd_err), 128'(0));
        check_outs("arst");
        step();
        rst_n = 1'b1;
        bus.wr_req = 8'h01;
        #1;
        chk("post-rst gnt", 128'(bus.wr_gnt), 128'(8'h01));
        chk("post-rst slot", 128'(bus.wr_slot[4:0]), 128'(0));
        step();
        bus.wr_req = 8'hFF;
        #1;
        chk("fill gnt", 128'(bus.wr_gnt), 128'(8'hFF));
        chk("fill slots", 128'(bus.wr_slot), 128'(seq_s(1)));
        step();
        bus.wr_req = 8'h01;
        step();
        bus.wr_req = 8'h00;
        bus.rd_req = 8'h0F; bus.rd_free = 8'h0F;
        for (int c = 0; c < 8; c++) bus.rd_slot[c*5 +: 5] = 5'(c);
        step();
        chk("free4 rd_valid", 128'(bus.rd_valid), 128'(8'h0F));
        chk("free4 empty", 128'(bus.empty), 128'(0));
        bus.rd_req = 8'h00; bus.rd_free = 8'h00;
        step();
`ifdef SPILL_OCCUPANCY_EN
        chk("occ_cnt", 128'(occ_cnt), 128'(6));
        chk("high_water", 128'(high_water), 128'(10));
`endif
        chk("idle pulse rd_valid", 128'(bus.rd_valid), 128'(0));
        bus.rd_req = 8'h3F; bus.rd_free = 8'h3F;
        for (int c = 0; c < 6; c++) bus.rd_slot[c*5 +: 5] = 5'(c + 4);
        step();
        chk("drain rd_valid", 128'(bus.rd_valid), 128'(8'h3F));
        chk("drain rd_err", 128'(bus.rd_err), 128'(0));
        chk("drain empty", 128'(bus.empty), 128'(1));
        bus.rd_req = 8'h00; bus.rd_free = 8'h00;
        step();
`ifdef SPILL_OCCUPANCY_EN
        chk("drain occ_cnt", 128'(occ_cnt), 128'(0));
        chk("drain high_water", 128'(high_water), 128'(10));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sparse_spill_buffer.md
# sparse_spill_buffer

Shared, parametrised spill buffer for a row of systolic PEs. It holds nonzero operands that a PE cannot consume immediately, storing each as a {data, index} word. It replaces fixed 8-port/4-port caches with one block generic in channel count, depth and widths. Each cycle it allocates free slots to requesting channels with a built-in free-slot finder, and frees slots on read-release.

## Interface
Parameters:
- N_CH, 8, number of PE channels
- DEPTH, 32, number of shared entries
- DW, 16, data width
- IW, 5, index (tag) width stored with each word
- AW, $clog2(DEPTH), slot address width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_req  in  N_CH  per-channel allocate+write request
- wr_data  in  N_CH*DW  write data, channel c at [c*DW +: DW]
- wr_idx  in  N_CH*IW  write index, packed likewise
- wr_gnt  out  N_CH  grant, combinational, same cycle as wr_req
- wr_slot  out  N_CH*AW  slot assigned to the granted channel, valid when wr_gnt[c]
- rd_req  in  N_CH  per-channel read request
- rd_slot  in  N_CH*AW  slot to read
- rd_free  in  N_CH  release the slot after the read; qualified by rd_req
- rd_valid  out  N_CH  registered, read data valid
- rd_data  out  N_CH*DW  registered read data
- rd_idx  out  N_CH*IW  registered read index
- rd_err  out  N_CH  registered, the read targeted an unoccupied slot
- full  out  1  no free slots (registered mask all ones)
- empty  out  1  no occupied slots

## Operation
- State: word array of DEPTH × (DW+IW), plus the registered occupancy mask `occ[DEPTH-1:0]`.
- Allocation (combinational from `occ` only):
  - Channels are scanned in ascending order.
  - Each requesting channel gets the lowest free slot not already given to a lower channel.
  - Grants stop when free slots run out; remaining requesters see wr_gnt=0 and must hold wr_req and their data.
- Write commit: at the posedge, each granted channel writes {wr_data, wr_idx} to its wr_slot and sets `occ`.
- Read: for each rd_req[c], at the posedge:
  - If the slot is occupied: rd_valid[c]=1, rd_data/rd_idx = stored word, rd_err[c]=0.
  - Otherwise: rd_valid[c]=0, rd_err[c]=1, and rd_data/rd_idx hold their previous values.
- Free: rd_req[c]&rd_free[c] on an occupied slot clears `occ` at the same posedge. Freeing an unoccupied slot only raises rd_err and has no state effect.
- Simultaneous events:
  - Several channels reading the same slot all receive the data; multiple frees of that slot clear it once, with no error.
  - A slot freed in cycle t is invisible to allocation until cycle t+1; no write/free race is possible on one slot.
  - A read of a slot being allocated in the same cycle sees it unoccupied: rd_err, no data.
- Reset (asynchronous, at any time, including mid-operation):
  - `occ`, rd_valid, rd_err, rd_data and rd_idx go to 0.
  - full=0, empty=1.
  - Array contents are don't-care.
  - In-flight grants are discarded.

## Timing
- Grant latency: 0 cycles, combinational from wr_req and `occ`.
- Write visible to reads: in the cycle after commit.
- Read latency: 1 cycle, registered outputs; rd_valid and rd_err are single-cycle pulses per request.
- full/empty: derived from `occ`; they update the cycle after the causing write or free.
- Throughput: N_CH writes plus N_CH reads per cycle, limited only by free slots.

## Configuration
- SPILL_OCCUPANCY_EN defined:
  - Adds outputs `occ_cnt` (out, $clog2(DEPTH+1)), the popcount of `occ`, registered.
  - Adds `high_water` (same width), the maximum occ_cnt since reset, monotonic, reset 0.
  - Both update one cycle after the `occ` change.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset then idle -> empty=1, full=0, all rd_valid/rd_err=0; assert rst_n low mid-traffic -> outputs cleared immediately, next grants start at slot 0.
- Empty buffer, all 8 wr_req high with data 0x1000+c, idx c -> wr_gnt=0xFF, wr_slot[c]=c; next cycle read slot 5 -> rd_data=0x1005, rd_idx=5.
- Fill 32 slots, then wr_req[3]=1 -> wr_gnt[3]=0, full=1. Free slot 17 -> next cycle full=0, channel 3 granted slot 17.
- With 2 free slots (9, 20) and requests on channels 1, 4, 6 -> ch1→9, ch4→20, ch6 no grant.
- Read+free slot 2 on channels 0 and 7 together -> both rd_valid with the same data; slot 2 freed once, no rd_err. Read of slot 2 the next cycle -> rd_err=1.
- SPILL_OCCUPANCY_EN: write 10 entries, free 4 -> occ_cnt=6, high_water=10.
